// File: rtl/neg10_arb_seq.sv
// neg10_arb_seq
//   Round-robin sequencer for the shared WIDTH-bit inverter. Two requesters
//   submit operands for bitwise NOT or two's-complement negation. The winner's
//   operand is driven onto the shared inverter, optionally incremented, and
//   returned as a tagged result.
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   req0/1, op0/1      request and operation (0 = NOT, 1 = NEG), held until gnt
//   data0/1            operand, held stable with req
//   gnt0/1             one-cycle grant pulse (operand already captured)
//   busy               high whenever the sequencer is not idle
//   not_in / not_out   shared inverter input drive / combinational output
//   res, res_id        result and owning requester, held between strobes
//   res_valid          one-cycle result strobe
//   ovf                NEG of the most-negative value overflowed
module neg10_arb_seq #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] not_in,
  input  logic [WIDTH-1:0] not_out,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_id,
  output logic             ovf
);

  // Inverted most-negative value: the only operand whose increment overflows.
  localparam logic [WIDTH-1:0] L_MAX_POS = ~(WIDTH'(1) << (WIDTH - 1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INV  = 2'd1,
    S_INC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opr;
  logic             r_op;
  logic             r_id;
  logic             r_last_id;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_busy;
  logic [WIDTH-1:0] r_not_in;
  logic [WIDTH-1:0] r_res;
  logic             r_res_valid;
  logic             r_res_id;
  logic             r_ovf;

  logic             w_pick;
  logic             w_sel_op;
  logic [WIDTH-1:0] w_sel_data;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  assign w_pick     = (req0 && req1) ? ~r_last_id : req1;
  assign w_sel_op   = w_pick ? op1 : op0;
  assign w_sel_data = w_pick ? data1 : data0;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_opr       <= '0;
      r_op        <= 1'b0;
      r_id        <= 1'b0;
      r_last_id   <= 1'b1;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_busy      <= 1'b0;
      r_not_in    <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      // Pulses and the inverter drive fall back to zero unless set below.
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_res_valid <= 1'b0;
      r_not_in    <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_id     <= w_pick;
            r_op     <= w_sel_op;
            r_opr    <= w_sel_data;
            r_not_in <= w_sel_data;
            r_gnt0   <= ~w_pick;
            r_gnt1   <= w_pick;
            r_busy   <= 1'b1;
            r_ovf    <= 1'b0;
            r_state  <= S_INV;
          end
        end
        S_INV: begin
          r_opr   <= not_out;
          r_state <= r_op ? S_INC : S_DONE;
        end
        S_INC: begin
          r_opr   <= r_opr + WIDTH'(1);
          r_ovf   <= (r_opr == L_MAX_POS);
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_res_valid <= 1'b1;
          r_res       <= r_opr;
          r_res_id    <= r_id;
          r_last_id   <= r_id;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign busy      = r_busy;
  assign not_in    = r_not_in;
  assign res       = r_res;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_neg10_arb_seq.sv
// Scoreboard bench for neg10_arb_seq: stimulus pushes expected grants and
// results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_neg10_arb_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [9:0] data0 = '0, data1 = '0;
  logic       gnt0, gnt1, busy, res_valid, res_id, ovf;
  logic [9:0] not_in, not_out, res;

  typedef struct {
    logic       id;
    logic [9:0] d;
  } gexp_t;

  typedef struct {
    logic [9:0] r;
    logic       id;
    logic       ovf;
    int         lat;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  int    gnt_cyc = 0;

  always #5 clk = ~clk;

  // Behavioural model of the shared inverter.
  assign not_out = ~not_in;

  neg10_arb_seq #(.WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .not_in(not_in), .not_out(not_out),
    .res(res), .res_valid(res_valid), .res_id(res_id), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: grants, inverter drive, busy and result strobes.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        chk("busy_at_gnt", 32'(busy), 32'd1);
        if (gq.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt1), 32'hDEAD);
        end else begin
          gexp_t g;
          g = gq.pop_front();
          chk("gnt_id", 32'(gnt1), 32'(g.id));
          chk("not_in_at_gnt", 32'(not_in), 32'(g.d));
        end
        gnt_cyc = cyc;
      end else begin
        chk("not_in_idle", 32'(not_in), 32'd0);
      end
      if (res_valid) begin
        chk("busy_at_rv", 32'(busy), 32'd0);
        if (rq.size() == 0) begin
          chk("unexpected_res_valid", 32'(res), 32'hDEAD);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("res", 32'(res), 32'(e.r));
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("ovf", 32'(ovf), 32'(e.ovf));
          chk("latency", 32'(cyc - gnt_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic push_exp(input bit id, input bit op, input logic [9:0] d,
                          input logic [9:0] er, input bit eovf);
    gexp_t g;
    rexp_t r;
    g.id = id; g.d = d;
    r.r = er; r.id = id; r.ovf = eovf; r.lat = op ? 3 : 2;
    gq.push_back(g);
    rq.push_back(r);
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) return;
    end
    chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rv();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (res_valid) return;
    end
    chk("res_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_req(input bit id, input bit op, input logic [9:0] d);
    if (id) begin op1 = op; data1 = d; req1 = 1'b1; end
    else    begin op0 = op; data0 = d; req0 = 1'b1; end
  endtask

  task automatic run_one(input bit id, input bit op, input logic [9:0] d,
                         input logic [9:0] er, input bit eovf);
    push_exp(id, op, d, er, eovf);
    drive_req(id, op, d);
    wait_gnt();
    req0 = 1'b0; req1 = 1'b0;
    wait_rv();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    int n0, n1;
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_not_in", 32'(not_in), 32'd0);

    // Single operations, including overflow and zero boundaries
    run_one(1'b0, 1'b1, 10'h005, 10'h3FB, 1'b0);
    run_one(1'b1, 1'b0, 10'h0F0, 10'h30F, 1'b0);
    run_one(1'b0, 1'b1, 10'h200, 10'h200, 1'b1);
    run_one(1'b1, 1'b1, 10'h000, 10'h000, 1'b0);
    run_one(1'b0, 1'b1, 10'h1FF, 10'h201, 1'b0);
    chk("res_held", 32'(res), 32'h201);

    // Both requesters held: grants alternate 0,1,0,1 after reset
    do_reset();
    push_exp(1'b0, 1'b1, 10'h00A, 10'h3F6, 1'b0);
    push_exp(1'b1, 1'b1, 10'h123, 10'h2DD, 1'b0);
    push_exp(1'b0, 1'b1, 10'h00A, 10'h3F6, 1'b0);
    push_exp(1'b1, 1'b1, 10'h123, 10'h2DD, 1'b0);
    op0 = 1'b1; data0 = 10'h00A; op1 = 1'b1; data1 = 10'h123;
    req0 = 1'b1; req1 = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 40 && (n0 < 2 || n1 < 2); i++) begin
      @(posedge clk); #1;
      if (gnt0) begin n0++; if (n0 == 2) req0 = 1'b0; end
      if (gnt1) begin n1++; if (n1 == 2) req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("alt_grant_count", 32'(n0 + n1), 32'd4);
    repeat (8) @(posedge clk);
    #1;

    // Reset while in INC aborts the operation without a strobe
    begin
      gexp_t g;
      g.id = 1'b0; g.d = 10'h0AB;
      gq.push_back(g);
    end
    drive_req(1'b0, 1'b1, 10'h0AB);
    wait_gnt();
    req0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_res_valid", 32'(res_valid), 32'd0);
    chk("abort_res", 32'(res), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    run_one(1'b0, 1'b0, 10'h3FF, 10'h000, 1'b0);
    run_one(1'b1, 1'b0, 10'h155, 10'h2AA, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    chk("grant_queue_empty", 32'(gq.size()), 32'd0);
    chk("result_queue_empty", 32'(rq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
